// File: rtl/rf_pkg.sv
// Shared sizes and types for the register file writeback path.
package rf_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers who won the last accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    // last_gnt1=1 means requester 1 won last, so requester 0 is favoured
    logic last_gnt1;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt1 <= 1'b1;
        end else if (accept) begin
            last_gnt1 <= gnt[1];
        end
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Shares one register file write port between ALU and load writebacks and
// tracks pending writers per register.
module regfile_wb_ctrl
    import rf_pkg::*;
#(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int NREGS = rf_pkg::NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    output logic             we,
    output logic [AW-1:0]    wa,
    output logic [XLEN-1:0]  wd,
    output logic [NREGS-1:0] busy
);
    // Handshake: reqN transfers on a rising edge where reqN_valid && reqN_ready;
    // ready depends only on the valids and the arbiter pointer, and is 0 in reset.
    logic [1:0]       gnt;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [XLEN-1:0]  sel_data;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid} & {2{rst_n}}),
        .accept (xfer),
        .gnt    (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;
    assign sel_addr   = gnt[1] ? req1_addr : req0_addr;
    assign sel_data   = gnt[1] ? req1_data : req0_data;

    // Set is applied after clear so a same-cycle issue to k keeps busy[k] high.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_addr != '0) begin
            set_mask = NREGS'(1) << issue_addr;
        end
        if (xfer) begin
            clr_mask = NREGS'(1) << sel_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we   <= 1'b0;
            wa   <= '0;
            wd   <= '0;
            busy <= '0;
        end else begin
            we   <= xfer && (sel_addr != '0);
            busy <= (busy & ~clr_mask) | set_mask;
            if (xfer && sel_addr != '0) begin
                wa <= sel_addr;
                wd <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: expected writes are queued at issue time
// and a negedge monitor compares them against the write port.
module tb_regfile_wb_ctrl;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int W     = AW + XLEN;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [AW-1:0]    req0_addr, req1_addr;
    logic [XLEN-1:0]  req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic             we;
    logic [AW-1:0]    wa;
    logic [XLEN-1:0]  wd;
    logic [NREGS-1:0] busy;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    regfile_wb_ctrl #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // monitor: every observed write must match the oldest queued expectation
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {1'b1, wa, wd}, '0);
            end else begin
                chk("write_port", {wa, wd}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        req0_addr = 5'd3; req0_data = 64'hAA;
        req1_addr = 5'd4; req1_data = 64'hBB;
        req0_valid = 1'b1;
        req1_valid = 1'b1;

        // reset with both requesters pending
        step(); step();
        chk("reset_ready", {req1_ready, req0_ready}, 2'b00);
        chk("reset_we", we, 1'b0);
        chk("reset_wa_wd", {wa, wd}, '0);
        chk("reset_busy", busy, '0);

        rst_n = 1'b1;
        #1;
        chk("first_grant_req0", {req1_ready, req0_ready}, 2'b01);

        // contention: grants alternate, one write per cycle
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                chk("rr_grant_even", {req1_ready, req0_ready}, 2'b01);
                push_write(5'd3, 64'hAA);
            end else begin
                chk("rr_grant_odd", {req1_ready, req0_ready}, 2'b10);
                push_write(5'd4, 64'hBB);
            end
            if (i > 0) chk("no_bubble_we", we, 1'b1);
            step();
        end
        idle_inputs();
        chk("last_contention_we", we, 1'b1);

        // write to x0 is accepted but suppressed
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'hFFFF;
        #1;
        chk("x0_ready", req1_ready, 1'b1);
        step();
        idle_inputs();
        chk("x0_we", we, 1'b0);
        chk("x0_busy", busy, '0);

        // issue then retire register 7
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        idle_inputs();
        chk("issue7_busy", busy, 32'h0000_0080);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h1234;
        push_write(5'd7, 64'h1234);
        step();
        idle_inputs();
        chk("retire7_busy", busy, '0);
        chk("retire7_we", {we, wa}, {1'b1, 5'd7});

        // issue to x0 is ignored
        issue_valid = 1'b1; issue_addr = 5'd0;
        step();
        idle_inputs();
        chk("issue0_busy", busy, '0);

        // same-register issue and retire: set wins
        issue_valid = 1'b1; issue_addr = 5'd5;
        step();
        chk("issue5_busy", busy, 32'h0000_0020);
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 64'h55;
        push_write(5'd5, 64'h55);
        step();
        idle_inputs();
        chk("collide5_busy", busy, 32'h0000_0020);
        chk("collide5_we", {we, wa}, {1'b1, 5'd5});

        // different-register issue and retire both apply
        issue_valid = 1'b1; issue_addr = 5'd6;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h5A5A;
        push_write(5'd5, 64'h5A5A);
        step();
        idle_inputs();
        chk("split_busy", busy, 32'h0000_0040);

        // mid-operation reset: pending write is dropped before the monitor sees it
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 64'h77;
        step();
        idle_inputs();
        chk("pre_reset_we", {we, wa}, {1'b1, 5'd10});
        rst_n = 1'b0;
        #1;
        chk("async_reset_we", we, 1'b0);
        chk("async_reset_busy", busy, '0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_we", we, 1'b0);
        step(); step();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter: XLEN, default 64, data width of the register file write port.
REQ-002 Parameter: NREGS, default 32, number of architectural registers; address width AW = log2(NREGS) = 5.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports, listed as name, direction, width and meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req0_valid, in, 1, ALU writeback request.
- req0_addr, in, AW, target register.
- req0_data, in, XLEN, write data.
- req0_ready, out, 1, request 0 accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as the req0 signals, for the load-unit writeback.
- issue_valid, in, 1, an instruction was issued that will write issue_addr.
- issue_addr, in, AW, destination register of the issued instruction.
- we, out, 1, register file write enable (registered).
- wa, out, AW, register file write address (registered).
- wd, out, XLEN, register file write data (registered).
- busy, out, NREGS, scoreboard; bit i = register i has a pending writer.

Function
REQ-005 The block SHALL share the single register file write port between req0 and req1, granting at most one request per cycle.
REQ-006 Handshake: a request transfers on a cycle where reqN_valid and reqN_ready are both 1; reqN_ready SHALL be combinational from the valids and the priority pointer, and a requester SHALL hold valid, addr and data stable until it is accepted.
REQ-007 Arbitration SHALL be round-robin:
- A single valid request is granted immediately.
- With both valid, grant the requester not granted most recently.
- The priority pointer updates only on a transfer; its reset value favours req0.
REQ-008 Latency: a transfer at edge N SHALL drive we=1, wa=addr and wd=data during cycle N+1; with no transfer, we=0 and wa/wd hold their previous values.
REQ-009 A transfer with addr=0 SHALL be accepted (ready=1) but SHALL produce we=0; register 0 is never written.
REQ-010 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-011 Scoreboard set: issue_valid=1 with issue_addr=k≠0 SHALL set busy[k] at the next edge.
REQ-012 Scoreboard clear: a transfer to addr=k SHALL clear busy[k] at the same edge, so busy[k] falls in the same cycle that we is asserted for k.
REQ-013 An issue and a transfer to the same k in the same cycle SHALL leave busy[k]=1 (set wins: a newer producer exists).
REQ-014 An issue and a transfer to different registers in the same cycle SHALL both take effect.
REQ-015 busy[0] SHALL be constant 0; issue_addr=0 SHALL be ignored.
REQ-016 A transfer to a non-busy register SHALL still write and SHALL leave busy unchanged (no error flag).

Reset
REQ-017 While rst_n=0: we=0, wa=0, wd=0, busy=0, priority pointer favours req0, and reqN_ready=0.
REQ-018 Assertion of rst_n mid-operation SHALL discard any pending write; the cycle after deassertion SHALL show we=0.
REQ-019 Deassertion is synchronous to clk externally; the block takes no transfers while rst_n=0.

Structure
REQ-020 The shared package rf_pkg SHALL hold XLEN, NREGS, AW and the typedefs reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [XLEN-1:0]).
REQ-021 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: 2 requests and an accept strobe; outputs: one-hot grant; owns the priority pointer).
REQ-022 The write-port registers and the scoreboard SHALL live in regfile_wb_ctrl; no other storage.

Verification
REQ-023 Reset: rst_n=0 with both valids high → ready=00, we=0, busy=0; release → first grant goes to req0.
REQ-024 Contention: req0 (addr 3, data 0xAA) and req1 (addr 4, data 0xBB) held valid → grants alternate 0,1,0,1; we=1 every cycle from N+1 with wa=3,4,3,4.
REQ-025 x0 write: req1 addr 0 data 0xFFFF → req1_ready=1, the next cycle we=0, busy unchanged.
REQ-026 Scoreboard: issue addr 7 → busy[7]=1 next cycle; req0 addr 7 transfer → busy[7]=0 in the same cycle that we=1 with wa=7.
REQ-027 Collision: issue addr 5 and a transfer to addr 5 in the same cycle with busy[5]=1 → busy[5] remains 1 and we=1 with wa=5.
REQ-028 Mid-op reset: assert rst_n=0 asynchronously in the cycle after a transfer → we drops to 0 immediately and busy clears to 0.
